decoder_scan: RTL

Parametrised, registered N-to-2^N one-hot decoder with a built-in scan sequencer. It generalises the fixed 4-to-16 enable decoder in two ways: select width is a parameter, and the output is registered. In direct mode it decodes a loaded index. In scan mode it walks the one-hot output across all 2^N lines, holding each line for a programmable dwell time. It sits between control logic and per-channel select/strobe lines, for example row/bank select or multiplexed-display scanning.

---
 rtl/decoder_pkg.sv | 18 +
 rtl/decoder_scan_timer.sv | 37 +++
 rtl/decoder_scan.sv | 74 +++++++
 3 files changed

// File: rtl/decoder_pkg.sv
// Shared constants and helpers for the registered one-hot decoder with scan sequencer.
package decoder_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Widest one-hot vector the helper can produce (select widths up to 10).
  localparam int unsigned ONEHOT_MAX_W = 1024;

  function automatic logic [ONEHOT_MAX_W-1:0] onehot(input int unsigned idx,
                                                     input int unsigned n);
    logic [ONEHOT_MAX_W-1:0] v;
    v = '0;
    if (idx < (32'd1 << n)) v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/decoder_scan_timer.sv
// Dwell counter for scan mode: counts enabled scan cycles and flags the last one.
module scan_timer #(
  parameter int unsigned DWELL = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clear,
  input  logic advance_ok,
  output logic tc
);

  localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [CW-1:0] dwell_q, dwell_d;

  // With DWELL = 1 the counter never leaves zero, so tc is constantly high.
  assign tc = (dwell_q == CW'(DWELL - 1));

  always_comb begin
    dwell_d = dwell_q;
    if (clear) begin
      dwell_d = '0;
    end else if (en && advance_ok) begin
      dwell_d = tc ? '0 : dwell_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_q <= '0;
    end else begin
      dwell_q <= dwell_d;
    end
  end

endmodule

// File: rtl/decoder_scan.sv
// Registered N-to-2^N one-hot decoder; direct mode decodes a loaded index,
// scan mode walks the active line across all outputs with a programmable dwell.
module decoder_scan
  import decoder_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned DWELL = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              mode,
  input  logic              load,
  input  logic [N-1:0]      in,
  output logic [2**N-1:0]   out,
  output logic [N-1:0]      idx,
  output logic              wrap
);

  localparam int unsigned OUT_W = 2**N;

  logic [N-1:0]     idx_q, idx_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             wrap_q, wrap_d;
  logic             tc;
  logic             scan_sel;
  logic             timer_clear;
  logic             advance;

  assign scan_sel    = (mode == MODE_SCAN);
  assign timer_clear = load || (mode == MODE_DIRECT);
  assign advance     = !load && scan_sel && en && tc;

  scan_timer #(
    .DWELL(DWELL)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .clear     (timer_clear),
    .advance_ok(scan_sel),
    .tc        (tc)
  );

  // Load beats a terminal-count advance; only an advance can raise wrap.
  always_comb begin
    idx_d  = idx_q;
    wrap_d = 1'b0;
    if (load) begin
      idx_d = in;
    end else if (advance) begin
      idx_d  = idx_q + N'(1);
      wrap_d = (idx_q == '1);
    end
    out_d = en ? OUT_W'(onehot(32'(idx_d), N)) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      out_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      out_q  <= out_d;
      wrap_q <= wrap_d;
    end
  end

  assign out  = out_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule
